// File: rtl/uart_rx_core.sv
// UART receive engine: 2-flop synchroniser, mid-bit sampling, parity/stop checks,
// and a single-character holding register with overrun detection and rts_n.
module uart_rx_core #(
  parameter int DIVISOR          = 10416,
  parameter int CNT_WIDTH        = 14,
  parameter int TRANS_DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  input  logic [1:0]                  cfg_data_bit,
  input  logic                        cfg_stop_bit,
  input  logic                        cfg_parity_en,
  input  logic                        cfg_parity_type,
  input  logic                        rx_rd,
  output logic [TRANS_DATA_WIDTH-1:0] rx_data,
  output logic                        rx_done,
  output logic                        rx_valid,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overrun_err,
  output logic                        rts_n
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DIVISOR - 1);
  // Preload so the first sample falls half a bit after the falling edge.
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DIVISOR - DIVISOR / 2);

  state_t                      state, state_nxt;
  logic                        rx_meta, rxs;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [2:0]                  bit_cnt, last_idx;
  logic [TRANS_DATA_WIDTH-1:0] shreg;
  logic [1:0]                  sh_data_bit;
  logic                        sh_stop_bit, sh_parity_en, sh_parity_type;
  logic                        p_err, f_err;
  logic                        sample, start_ok, stop_low, complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign last_idx = 3'd4 + {1'b0, sh_data_bit};
  assign sample   = (state != IDLE) && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!rxs) state_nxt = START;
      START:  if (sample) state_nxt = rxs ? IDLE : DATA;
      DATA:   if (sample && bit_cnt == last_idx) state_nxt = sh_parity_en ? PARITY : STOP1;
      PARITY: if (sample) state_nxt = STOP1;
      STOP1:  if (sample) state_nxt = sh_stop_bit ? STOP2 : IDLE;
      STOP2:  if (sample) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ok = (state == START) && sample && !rxs;
    stop_low = sample && !rxs && (state == STOP1 || state == STOP2);
    complete = sample && ((state == STOP1 && !sh_stop_bit) || state == STOP2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      sh_data_bit    <= '0;
      sh_stop_bit    <= 1'b0;
      sh_parity_en   <= 1'b0;
      sh_parity_type <= 1'b0;
      p_err          <= 1'b0;
      f_err          <= 1'b0;
    end else begin
      if (state == IDLE) cnt <= CNT_LOAD;
      else               cnt <= sample ? '0 : cnt + 1'b1;
      // Frame configuration is frozen once the start bit is confirmed.
      if (start_ok) begin
        sh_data_bit    <= cfg_data_bit;
        sh_stop_bit    <= cfg_stop_bit;
        sh_parity_en   <= cfg_parity_en;
        sh_parity_type <= cfg_parity_type;
        shreg          <= '0;
        bit_cnt        <= '0;
        p_err          <= 1'b0;
        f_err          <= 1'b0;
      end
      if (state == DATA && sample) begin
        shreg[bit_cnt] <= rxs;
        bit_cnt        <= bit_cnt + 3'd1;
      end
      if (state == PARITY && sample)
        p_err <= rxs != (sh_parity_type ? ^shreg : ~^shreg);
      if (stop_low) f_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_done     <= 1'b0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (complete) begin
        if (!rx_valid || rx_rd) begin
          rx_data     <= shreg;
          parity_err  <= p_err;
          frame_err   <= f_err | stop_low;
          rx_valid    <= 1'b1;
          rx_done     <= 1'b1;
          overrun_err <= 1'b0;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_rd && rx_valid) begin
        rx_valid    <= 1'b0;
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

  assign rts_n = rx_valid;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with a short bit period; expected values are hand-computed.
module tb_uart_rx_core;

  localparam int DIV = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] cfg_data_bit = 2'd3;
  logic       cfg_stop_bit = 1'b0;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_type = 1'b0;
  logic       rx_rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done, rx_valid, parity_err, frame_err, overrun_err, rts_n;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_base;

  uart_rx_core #(.DIVISOR(DIV), .CNT_WIDTH(7), .TRANS_DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .cfg_data_bit(cfg_data_bit), .cfg_stop_bit(cfg_stop_bit),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_type(cfg_parity_type),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_done(rx_done), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
    .rts_n(rts_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rx_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic sb, input logic pe, input logic pt);
    @(negedge clk);
    cfg_data_bit = db; cfg_stop_bit = sb; cfg_parity_en = pe; cfg_parity_type = pt;
  endtask

  // A low stop bit is held for only 3/4 of a bit so the line is high again
  // before the receiver could mistake it for a new start bit.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input bit pbit,
                            input int ns, input bit sval);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      repeat (DIV) @(negedge clk);
    end
    if (pe) begin
      rx = pbit;
      repeat (DIV) @(negedge clk);
    end
    for (int s = 0; s < ns; s++) begin
      rx = sval;
      repeat (sval ? DIV : (DIV * 3) / 4) @(negedge clk);
    end
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_rts", rts_n, 0);
    check("rst_errs", {parity_err, frame_err, overrun_err, rx_done}, 0);
    rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);

    // 8N1 0x49
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    done_base = done_cnt;
    send_frame(8'h49, 8, 0, 0, 1, 1);
    check("8n1_done", done_cnt - done_base, 1);
    check("8n1_data", rx_data, 8'h49);
    check("8n1_errs", {parity_err, frame_err, overrun_err}, 0);
    check("8n1_valid", rx_valid, 1);
    check("8n1_rts", rts_n, 1);
    rd_pulse();
    check("8n1_rd_valid", rx_valid, 0);

    // 8E1 0xB6, five ones -> parity bit 1
    set_cfg(2'd3, 1'b0, 1'b1, 1'b1);
    send_frame(8'hB6, 8, 1, 1, 1, 1);
    check("8e1_data", rx_data, 8'hB6);
    check("8e1_perr", parity_err, 0);
    rd_pulse();

    // 8E2 0xC2, three ones -> parity should be 1, sent 0
    set_cfg(2'd3, 1'b1, 1'b1, 1'b1);
    send_frame(8'hC2, 8, 1, 0, 2, 1);
    check("8e2_data", rx_data, 8'hC2);
    check("8e2_perr", parity_err, 1);
    check("8e2_ferr", frame_err, 0);
    rd_pulse();
    check("8e2_rd_perr", parity_err, 0);

    // 5N1 0xFF
    set_cfg(2'd0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 5, 0, 0, 1, 1);
    check("5n1_data", rx_data, 8'h1F);
    rd_pulse();

    // 8N1 with low stop bit
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    done_base = done_cnt;
    send_frame(8'h3C, 8, 0, 0, 1, 0);
    check("fe_done", done_cnt - done_base, 1);
    check("fe_data", rx_data, 8'h3C);
    check("fe_ferr", frame_err, 1);
    rd_pulse();
    check("fe_rd_valid", rx_valid, 0);
    check("fe_rd_errs", {parity_err, frame_err, overrun_err}, 0);

    // Glitch shorter than half a bit
    done_base = done_cnt;
    rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("glitch_done", done_cnt - done_base, 0);
    check("glitch_valid", rx_valid, 0);

    // Overrun: 0x11 then 0x22 without a read
    done_base = done_cnt;
    send_frame(8'h11, 8, 0, 0, 1, 1);
    send_frame(8'h22, 8, 0, 0, 1, 1);
    check("ovr_done", done_cnt - done_base, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_flag", overrun_err, 1);
    check("ovr_valid", rx_valid, 1);

    // Reset in the middle of the data bits
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (DIV) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst_data", rx_data, 0);
    check("mrst_flags", {rx_valid, overrun_err, rts_n, rx_done}, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("mrst_nodone", rx_valid, 0);
    done_base = done_cnt;
    send_frame(8'h5A, 8, 0, 0, 1, 1);
    check("post_done", done_cnt - done_base, 1);
    check("post_data", rx_data, 8'h5A);
    check("post_errs", {parity_err, frame_err, overrun_err}, 0);
    rd_pulse();
    check("post_rd_valid", rx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
